// File: rtl/v11_peak_detector_pkg.sv
// Shared widths, FSM state type and event record layout for the v11 peak detector slice.
package v11_peak_detector_pkg;

    localparam int SIZE_FILTER_DATA = 15;
    localparam int SIZE_TIMESTAMP   = 32;
    localparam int SIZE_LOST_COUNT  = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DEAD
    } peakState_t;

    typedef struct packed {
        logic signed [SIZE_FILTER_DATA:0] amplitude;
        logic [SIZE_TIMESTAMP-1:0]        timeStamp;
        logic                             pileup;
    } peakRecord_t;

    // Saturates at all-ones so a long stall never wraps the drop counter back to a small value.
    function automatic logic [SIZE_LOST_COUNT-1:0] satIncrement(input logic [SIZE_LOST_COUNT-1:0] value);
        return (&value) ? value : value + SIZE_LOST_COUNT'(1);
    endfunction

endpackage

// File: rtl/v11_peak_out_buffer.sv
// Single-entry valid/ready holding register for peak event records.
// A record arriving while an unaccepted one is held is dropped and counted.
module v11_peak_out_buffer
    import v11_peak_detector_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_emit,
    input  logic signed [SIZE_FILTER_DATA:0] i_amplitude,
    input  logic [SIZE_TIMESTAMP-1:0]      i_time,
    input  logic                           i_pileup,
    input  logic                           i_outReady,
    output logic                           o_valid,
    output logic signed [SIZE_FILTER_DATA:0] o_amplitude,
    output logic [SIZE_TIMESTAMP-1:0]      o_time,
    output logic                           o_pileup,
    output logic [SIZE_LOST_COUNT-1:0]     o_lostCount
);

    logic                       r_valid;
    peakRecord_t                r_record;
    logic [SIZE_LOST_COUNT-1:0] r_lostCount;
    peakRecord_t                w_inRecord;

    assign w_inRecord = '{amplitude: i_amplitude, timeStamp: i_time, pileup: i_pileup};

    // The held record may be replaced in the same edge it is accepted, so back-to-back events need no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_record    <= '0;
            r_lostCount <= '0;
        end else begin
            if (i_emit) begin
                if (!r_valid || i_outReady) begin
                    r_record <= w_inRecord;
                    r_valid  <= 1'b1;
                end else begin
                    r_lostCount <= satIncrement(r_lostCount);
                end
            end else if (r_valid && i_outReady) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_amplitude = r_record.amplitude;
    assign o_time      = r_record.timeStamp;
    assign o_pileup    = r_record.pileup;
    assign o_lostCount = r_lostCount;

endmodule

// File: rtl/v11_peak_detector.sv
// Threshold/hysteresis pulse detector on the shaped filter stream: finds each pulse's peak
// amplitude and timestamp, flags pile-up, and hands one record per pulse to the output buffer.
module v11_peak_detector
    import v11_peak_detector_pkg::*;
#(
    parameter int THRESHOLD = 64,
    parameter int HYST      = 16,
    parameter int MAX_WIDTH = 64,
    parameter int DEAD_TIME = 8
)(
    input  logic                             clk,
    input  logic                             reset,
    input  logic signed [SIZE_FILTER_DATA:0] filter_data,
    input  logic                             out_ready,
    output logic                             peak_valid,
    output logic signed [SIZE_FILTER_DATA:0] peak_amplitude,
    output logic [SIZE_TIMESTAMP-1:0]        peak_time,
    output logic                             peak_pileup,
    output logic [SIZE_LOST_COUNT-1:0]       lost_count
);

    localparam int DW         = SIZE_FILTER_DATA + 1;
    localparam int WIDTH_BITS = $clog2(MAX_WIDTH + 1);
    localparam int DEAD_BITS  = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

    localparam logic signed [DW-1:0] C_THRESHOLD = DW'(THRESHOLD);
    localparam logic signed [DW-1:0] C_LOW       = DW'(THRESHOLD - HYST);
    localparam logic signed [DW:0]   C_HYST      = (DW + 1)'(HYST);
    localparam logic [WIDTH_BITS-1:0] C_MAX_WIDTH = WIDTH_BITS'(MAX_WIDTH);
    localparam logic [DEAD_BITS-1:0]  C_DEAD_TIME = DEAD_BITS'(DEAD_TIME);

    peakState_t                r_state;
    logic [SIZE_TIMESTAMP-1:0] r_ts;
    logic signed [DW-1:0]      r_max;
    logic [SIZE_TIMESTAMP-1:0] r_tmax;
    logic [WIDTH_BITS-1:0]     r_width;
    logic [DEAD_BITS-1:0]      r_dead;
    logic                      r_pileup;
    logic                      r_fallen;

    logic                      w_aboveThreshold;
    logic                      w_belowLow;
    logic                      w_newMax;
    logic signed [DW:0]        w_sampleExt;
    logic signed [DW:0]        w_maxMinusHyst;
    logic                      w_hasFallen;
    logic [WIDTH_BITS-1:0]     w_widthNext;
    logic                      w_emit;

    assign w_aboveThreshold = filter_data > C_THRESHOLD;
    assign w_belowLow       = filter_data < C_LOW;
    assign w_newMax         = filter_data > r_max;

    // One guard bit keeps max - HYST from wrapping when max sits near the negative limit.
    assign w_sampleExt    = $signed({filter_data[DW-1], filter_data});
    assign w_maxMinusHyst = $signed({r_max[DW-1], r_max}) - C_HYST;
    assign w_hasFallen    = w_sampleExt <= w_maxMinusHyst;

    assign w_widthNext = r_width + WIDTH_BITS'(1);
    assign w_emit      = (r_state == ARMED) && w_belowLow;

    // Free-running sample timestamp; wraps naturally at its full width.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + SIZE_TIMESTAMP'(1);
        end
    end

    // Pulse tracking FSM: a rise after a hysteresis-sized dip within one pulse means two overlapping pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_max    <= '0;
            r_tmax   <= '0;
            r_width  <= '0;
            r_dead   <= '0;
            r_pileup <= 1'b0;
            r_fallen <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_aboveThreshold) begin
                        r_state  <= ARMED;
                        r_max    <= filter_data;
                        r_tmax   <= r_ts;
                        r_width  <= WIDTH_BITS'(1);
                        r_pileup <= (C_MAX_WIDTH <= WIDTH_BITS'(1));
                        r_fallen <= 1'b0;
                    end
                end
                ARMED: begin
                    if (w_belowLow) begin
                        r_state <= DEAD;
                        r_dead  <= C_DEAD_TIME;
                    end else begin
                        if (w_newMax) begin
                            r_max  <= filter_data;
                            r_tmax <= r_ts;
                            if (r_fallen) begin
                                r_pileup <= 1'b1;
                            end
                        end
                        if (w_hasFallen) begin
                            r_fallen <= 1'b1;
                        end
                        if (r_width < C_MAX_WIDTH) begin
                            r_width <= w_widthNext;
                            if (w_widthNext == C_MAX_WIDTH) begin
                                r_pileup <= 1'b1;
                            end
                        end
                    end
                end
                DEAD: begin
                    if (r_dead != '0) begin
                        r_dead <= r_dead - DEAD_BITS'(1);
                    end else if (w_belowLow) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    v11_peak_out_buffer u_outBuffer (
        .clk         (clk),
        .reset       (reset),
        .i_emit      (w_emit),
        .i_amplitude (r_max),
        .i_time      (r_tmax),
        .i_pileup    (r_pileup),
        .i_outReady  (out_ready),
        .o_valid     (peak_valid),
        .o_amplitude (peak_amplitude),
        .o_time      (peak_time),
        .o_pileup    (peak_pileup),
        .o_lostCount (lost_count)
    );

endmodule

// File: doc/v11_peak_detector.md
# v11_peak_detector

Downstream consumer of the v11 trapezoidal shaping filter. Takes the shaped sample stream (one sample per clock), detects pulses crossing a threshold, and extracts the peak amplitude and the peak timestamp. It also flags pile-up and presents one event record per pulse on a valid/ready output. It sits between the filter output and the event readout logic.

## Interface
- `THRESHOLD`, 64: arming level; a sample arms only if strictly greater, signed compare.
- `HYST`, 16: hysteresis. Low threshold `LOW = THRESHOLD - HYST`. Requires `0 < HYST < THRESHOLD`.
- `MAX_WIDTH`, 64: maximum number of armed samples before the pulse is flagged as pile-up.
- `DEAD_TIME`, 8: hold-off cycles after each pulse ends.
- `clk`, in, 1: sole clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `filter_data`, in, `SIZE_FILTER_DATA+1`: shaped sample, signed two's complement, valid every cycle.
- `out_ready`, in, 1: downstream accepts the event record.
- `peak_valid`, out, 1: event record available.
- `peak_amplitude`, out, `SIZE_FILTER_DATA+1`: signed maximum sample of the pulse.
- `peak_time`, out, `SIZE_TIMESTAMP`: timestamp of the maximum sample.
- `peak_pileup`, out, 1: pile-up flag.
- `lost_count`, out, `SIZE_LOST_COUNT`: saturating count of dropped events.

## Operation
- **Timestamp counter `ts`.**
  - Free-running; 0 after reset; +1 every cycle; wraps to 0.
  - A sample's timestamp is the `ts` value in the cycle the sample is present on `filter_data`.
- **FSM states:** IDLE, ARMED, DEAD.
- **IDLE → ARMED** when `filter_data > THRESHOLD`.
  - Load `max = filter_data` and `tmax = ts`.
  - Set `width = 1` and `pileup = 0`.
  - Clear `fallen`.
- **In ARMED, per sample `x`** (while `x >= LOW`):
  - `x > max`: update `max` and `tmax`. Strictly greater, so on ties the first occurrence is kept.
  - If `fallen` was set and `x > max`: set `pileup`.
  - `x <= max - HYST`: set `fallen` (signed arithmetic, one extra guard bit).
  - Increment `width`, saturating at `MAX_WIDTH`. Reaching `MAX_WIDTH` sets `pileup`.
- **ARMED → DEAD** when `x < LOW`.
  - That sample is not a max candidate.
  - The event `{max, tmax, pileup}` is emitted.
  - The dead counter is loaded with `DEAD_TIME`.
- **DEAD → IDLE** requires both the counter to reach 0 and `filter_data < LOW`.
  - Otherwise stay in DEAD, with the counter held at 0.
  - Samples in DEAD are ignored.
- **Output register** (single entry):
  - Emit while `peak_valid=0`, or while `peak_valid & out_ready`: load the record and set `peak_valid=1`.
  - Emit while `peak_valid & !out_ready`: drop the new event and increment `lost_count`, saturating at all-ones. The held record is unchanged.
  - `peak_valid & out_ready` with no emit: `peak_valid=0` next cycle.
  - `peak_valid` and the record fields stay stable until accepted.
- **Reset:**
  - FSM → IDLE; `ts`, counters and flags cleared.
  - All outputs 0: `peak_valid=0`, `peak_amplitude=0`, `peak_time=0`, `peak_pileup=0`, `lost_count=0`.
  - A pulse in progress, or a held record, is discarded without emission.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- Latency: if the falling sample (`< LOW`) is present in cycle c, then `peak_valid=1` in cycle c+1.
- Throughput: at most one event per `DEAD_TIME+2` cycles. A transfer completes on any edge with `peak_valid & out_ready`.

## Structure
- `package_settings` adds `SIZE_TIMESTAMP`, 32, and `SIZE_LOST_COUNT`, 16.
- `v11_filter_parameters` adds the FSM state enum typedef (`IDLE`, `ARMED`, `DEAD`) and a packed event-record struct `{amplitude, time, pileup}`.
- Sub-module `v11_peak_out_buffer`:
  - Single-entry valid/ready holding register.
  - Contains the drop logic and the saturating `lost_count`.
- The FSM, `ts`, and the width and dead counters live in the top module.

## Test plan
Defaults: `THRESHOLD=64`, `HYST=16` (so `LOW=48`), `MAX_WIDTH=64`, `DEAD_TIME=8`. Baseline 0, `out_ready=1` unless stated.
- **Single pulse.** Samples 70, 100, 130, 90, 40 in cycles 10–14 → `peak_valid` in cycle 15, amplitude 130, time 12, pileup 0. Then a constant 64 → never arms.
- **Double peak.** Samples 70, 120, 60, 150, 40 from cycle 20 → amplitude 150, time 23, pileup 1. Because 60 ≤ 104 sets `fallen`, then 150 > 120.
- **Long pulse.** 80 held for 70 cycles from cycle 5, then 0 → amplitude 80, time 5, pileup 1.
- **Back-pressure.** `out_ready=0` with two pulses (peaks 100 and 200) separated by 20 cycles → first record held; `lost_count=1`. Raising `out_ready` → exactly one transfer, of amplitude 100.
- **Dead time.** A second pulse starts 3 cycles after the first falls → ignored. A pulse starting 12 cycles after the fall is detected normally.
- **Reset mid-pulse.** `reset` asserted in ARMED for one cycle → no event emitted; `ts=0` and `lost_count=0` next cycle. A subsequent pulse is detected with its time counted from reset.
